modaddsub_serial: RTL and testbench

MODADDSUB_SERIAL -- requirements
Module: modaddsub_serial

---
 rtl/modaddsub_serial_if.sv | 33 +++
 rtl/modaddsub_serial.sv | 147 ++++++++++++++
 tb/tb_modaddsub_serial.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/modaddsub_serial_if.sv
// Request/response bundle for modaddsub_serial; the optional reduced flag is present
// only when MODADDSUB_REDUCED_FLAG_EN is defined.
interface modaddsub_serial_if #(
    parameter int WIDTH = 381
);
    logic             start;
    logic             subtract;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
`ifdef MODADDSUB_REDUCED_FLAG_EN
    logic             reduced;
`endif

    modport master (
        output start, subtract, in_a, in_b, in_m,
        input  result, done, busy
`ifdef MODADDSUB_REDUCED_FLAG_EN
        , input reduced
`endif
    );

    modport slave (
        input  start, subtract, in_a, in_b, in_m,
        output result, done, busy
`ifdef MODADDSUB_REDUCED_FLAG_EN
        , output reduced
`endif
    );
endinterface

// File: rtl/modaddsub_serial.sv
// Digit-serial modular add/subtract: (a+b) mod m or (a-b) mod m, DIGIT bits per cycle.
// Latency: NDIG+1 cycles from the start-sampling edge to the one-cycle done pulse.
// Backpressure: start is ignored while busy; DONE accepts a new start (back-to-back). Option: MODADDSUB_REDUCED_FLAG_EN.
module modaddsub_serial #(
    parameter int WIDTH = 381,
    parameter int DIGIT = 64
) (
    input  logic                clk,
    input  logic                resetn,
    modaddsub_serial_if.slave   bus
);
    localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int EXT  = NDIG * DIGIT;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIG);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             cs, cs_nxt;
    logic             ct, ct_nxt;
    logic [WIDTH-1:0] result_q, result_nxt;
    logic             accept;
    logic             slice_en;
    logic             sel_t;

    logic             sub_q;
    logic [EXT-1:0]   a_sh, b_sh, m_sh;
    logic [EXT-1:0]   s_sh, t_sh;

    logic [DIGIT-1:0] a_d, b_d, m_d;
    logic [DIGIT:0]   s_ext, t_ext;

`ifdef MODADDSUB_REDUCED_FLAG_EN
    logic             red_q, red_nxt;
`endif

    // cs/ct hold carry (add) or borrow (sub) of chains S and T respectively.
    always_comb begin
        a_d = a_sh[DIGIT-1:0];
        b_d = b_sh[DIGIT-1:0];
        m_d = m_sh[DIGIT-1:0];
        if (sub_q) begin
            s_ext = {1'b0, a_d} - {1'b0, b_d} - {{DIGIT{1'b0}}, cs};
            t_ext = {1'b0, s_ext[DIGIT-1:0]} + {1'b0, m_d} + {{DIGIT{1'b0}}, ct};
        end else begin
            s_ext = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, cs};
            t_ext = {1'b0, s_ext[DIGIT-1:0]} - {1'b0, m_d} - {{DIGIT{1'b0}}, ct};
        end
    end

    // Add: a+b >= m shows as carry out of S or no borrow out of S-m. Sub: a<b borrows.
    assign sel_t = sub_q ? cs : (cs | ~ct);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cs_nxt     = cs;
        ct_nxt     = ct;
        result_nxt = result_q;
        accept     = 1'b0;
        slice_en   = 1'b0;
`ifdef MODADDSUB_REDUCED_FLAG_EN
        red_nxt    = red_q;
`endif
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    cs_nxt    = 1'b0;
                    ct_nxt    = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (cnt != LAST) begin
                    slice_en = 1'b1;
                    cnt_nxt  = cnt + CW'(1);
                    cs_nxt   = s_ext[DIGIT];
                    ct_nxt   = t_ext[DIGIT];
                end else begin
                    state_nxt  = DONE;
                    result_nxt = sel_t ? t_sh[WIDTH-1:0] : s_sh[WIDTH-1:0];
`ifdef MODADDSUB_REDUCED_FLAG_EN
                    red_nxt    = sel_t;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            cs       <= 1'b0;
            ct       <= 1'b0;
            result_q <= '0;
`ifdef MODADDSUB_REDUCED_FLAG_EN
            red_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cs       <= cs_nxt;
            ct       <= ct_nxt;
            result_q <= result_nxt;
`ifdef MODADDSUB_REDUCED_FLAG_EN
            red_q    <= red_nxt;
`endif
        end
    end

    // Operands shift down one digit per slice; S and T fill in from the top so the
    // full-width sums sit aligned at bit 0 once the last slice has gone in.
    always_ff @(posedge clk) begin
        if (accept) begin
            sub_q <= bus.subtract;
            a_sh  <= EXT'(bus.in_a);
            b_sh  <= EXT'(bus.in_b);
            m_sh  <= EXT'(bus.in_m);
        end else if (slice_en) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            m_sh  <= m_sh >> DIGIT;
            s_sh  <= (s_sh >> DIGIT) | (EXT'(s_ext[DIGIT-1:0]) << (EXT - DIGIT));
            t_sh  <= (t_sh >> DIGIT) | (EXT'(t_ext[DIGIT-1:0]) << (EXT - DIGIT));
        end
    end

    // Padding digits above WIDTH are computed but never reach the result.
    logic unused_pad;
    assign unused_pad = ^{s_sh, t_sh};

    assign bus.result = result_q;
    assign bus.done   = (state == DONE);
    assign bus.busy   = (state == RUN);
`ifdef MODADDSUB_REDUCED_FLAG_EN
    assign bus.reduced = red_q;
`endif

endmodule

// File: tb/tb_modaddsub_serial.sv
// Scoreboard bench for modaddsub_serial over four configurations (381/64, 381/1, 381/381, 8/3).
// Expected results come from plain modular arithmetic; a monitor pops and checks on each done.
module tb_modaddsub_serial;
    typedef struct packed {
        logic [1:0]   inst;
        logic         red;
        logic [380:0] res;
        logic [31:0]  due;
    } exp_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic         st[4];
    logic         sb[4];
    logic [380:0] ta[4], tbv[4], tm[4], res[4];
    logic         dn[4], bz[4];
`ifdef MODADDSUB_REDUCED_FLAG_EN
    logic         rd[4];
`endif

    exp_t exq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int W = (g == 3) ? 8 : 381;
        localparam int D = (g == 0) ? 64 : (g == 1) ? 1 : (g == 2) ? 381 : 3;
        modaddsub_serial_if #(.WIDTH(W)) bus ();
        modaddsub_serial #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .resetn(resetn), .bus(bus));
        assign bus.start    = st[g];
        assign bus.subtract = sb[g];
        assign bus.in_a     = ta[g][W-1:0];
        assign bus.in_b     = tbv[g][W-1:0];
        assign bus.in_m     = tm[g][W-1:0];
        assign res[g]       = 381'(bus.result);
        assign dn[g]        = bus.done;
        assign bz[g]        = bus.busy;
`ifdef MODADDSUB_REDUCED_FLAG_EN
        assign rd[g]        = bus.reduced;
`endif
    end

    function automatic int width_of(input int d);
        return (d == 3) ? 8 : 381;
    endfunction

    function automatic int ndig_of(input int d);
        case (d)
            0:       return 6;
            1:       return 381;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    // Returns {reduced, result}.
    function automatic logic [381:0] golden(input logic sub, input logic [380:0] a, b, m);
        logic [381:0] s;
        if (!sub) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, m}) return {1'b1, 381'(s - {1'b0, m})};
            return {1'b0, s[380:0]};
        end
        if (a < b) begin
            s = {1'b0, a} + {1'b0, m} - {1'b0, b};
            return {1'b1, s[380:0]};
        end
        return {1'b0, a - b};
    endfunction

    function automatic logic [380:0] rnd(input int w);
        logic [380:0] v = '0;
        logic [380:0] mask = {381{1'b1}};
        for (int k = 0; k < 12; k++) v = {v[348:0], 32'($urandom())};
        return v & (mask >> (381 - w));
    endfunction

    task automatic chk(input string nm, input logic [380:0] got, input logic [380:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic issue(input int d, input logic sub, input logic [380:0] a, b, m);
        int   w = 0;
        exp_t e;
        @(negedge clk);
        while (bz[d] && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (bz[d]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: inst %0d still busy after %0d cycles, required idle", d, w);
        end
        st[d] = 1'b1; sb[d] = sub; ta[d] = a; tbv[d] = b; tm[d] = m;
        @(posedge clk);
        #1;
        e.inst = 2'(d);
        {e.red, e.res} = golden(sub, a, b, m);
        e.due = 32'(cyc + ndig_of(d) + 1);
        exq.push_back(e);
        st[d] = 1'b0;
        chk("busy_after_start", 381'(bz[d]), 381'(1));
    endtask

    task automatic drain();
        int w = 0;
        while (exq.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (exq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exq.size());
            exq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_random(input int d, input int n);
        int           w;
        logic [380:0] a, b, m;
        logic         sub;
        w = width_of(d);
        for (int i = 0; i < n; i++) begin
            m = (i == 4) ? rnd(381) | {381{1'b1}} : rnd(w);
            if (i == 4) m = m >> (381 - w);
            if (m < 2) m = 2;
            a = rnd(w) % m;
            b = rnd(w) % m;
            sub = 1'($urandom_range(0, 1));
            case (i)
                0: begin b = a; sub = 1'b1; end
                1: begin if (a == 0) a = 1; b = m - a; sub = 1'b0; end
                2: begin a = m - 1; b = m - 1; sub = 1'b0; end
                3: begin a = 0; b = m - 1; sub = 1'b1; end
                default: ;
            endcase
            issue(d, sub, a, b, m);
        end
        drain();
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 4; g++) begin
            if (dn[g] === 1'b1) begin
                if (exq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_done: inst %0d pulsed done, required no pulse", g);
                end else begin
                    e = exq.pop_front();
                    chk("done_inst", 381'(g), 381'(e.inst));
                    chk("result", res[g], e.res);
                    chk("latency_cycle", 381'(cyc), 381'(e.due));
                    chk("busy_in_done", 381'(bz[g]), 381'(0));
`ifdef MODADDSUB_REDUCED_FLAG_EN
                    chk("reduced", 381'(rd[g]), 381'(e.red));
`endif
                end
            end
        end
    end

    initial begin
        for (int g = 0; g < 4; g++) begin
            st[g] = 1'b0; sb[g] = 1'b0; ta[g] = '0; tbv[g] = '0; tm[g] = '0;
        end
        #2 resetn = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("reset_result", res[g], '0);
            chk("reset_done", 381'(dn[g]), 381'(0));
            chk("reset_busy", 381'(bz[g]), 381'(0));
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Directed: small operands on the wide datapath, back-to-back from DONE.
        issue(0, 1'b1, 381'd1, 381'd2, 381'd5);
        drain();
        issue(0, 1'b0, 381'd3, 381'd4, 381'd5);
        issue(0, 1'b0, 381'd1, 381'd1, 381'd5);
        drain();
        chk("result_held", res[0], 381'd2);

        // Narrow instance: carry out of the top digit, and a-a.
        issue(3, 1'b0, 381'd200, 381'd100, 381'd251);
        issue(3, 1'b1, 381'd7, 381'd7, 381'd11);
        drain();

        // Start re-asserted two cycles into RUN with different operands must be ignored.
        issue(0, 1'b0, 381'd4, 381'd3, 381'd5);
        @(posedge clk);
        #1;
        st[0] = 1'b1; sb[0] = 1'b1; ta[0] = 381'd9; tbv[0] = 381'd1; tm[0] = 381'd13;
        @(posedge clk);
        #1;
        st[0] = 1'b0; ta[0] = rnd(381); tbv[0] = rnd(381); tm[0] = rnd(381);
        drain();

        // Reset pulse mid-RUN aborts without a done pulse.
        issue(0, 1'b0, 381'd4, 381'd4, 381'd5);
        @(posedge clk);
        #1;
        void'(exq.pop_back());
        resetn = 1'b0;
        #1;
        chk("abort_result", res[0], '0);
        chk("abort_done", 381'(dn[0]), 381'(0));
        chk("abort_busy", 381'(bz[0]), 381'(0));
`ifdef MODADDSUB_REDUCED_FLAG_EN
        chk("abort_reduced", 381'(rd[0]), 381'(0));
`endif
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_result", res[0], '0);
        issue(0, 1'b0, 381'd2, 381'd2, 381'd5);
        drain();

        run_random(0, 20);
        run_random(2, 20);
        run_random(3, 20);
        run_random(1, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
